vector_output_serializer: RTL and testbench
===========================================

Name: vector_output_serializer

Overview:
- Sits directly downstream of the CPU's vector output port.
- Each outFlag cycle, the CPU presents VECTOR_SIZE lanes of OUTPUT_WIDTH bits each. This block captures those vectors into a small FIFO.
- It serializes them one lane per beat onto a valid/ready byte stream for the image sink.
- It counts pixels per frame, emits a frame-done pulse, and flags vectors lost to overflow because the CPU cannot stall.

Parameters:
- VECTOR_SIZE, 6, lanes per input vector.
- OUTPUT_WIDTH, 8, bits per lane/pixel.
- FIFO_DEPTH, 4, vector entries buffered; power of two, >=2.
- FRAME_PIXELS, 76800, pixels per frame; >=1.
- CNT_WIDTH, 17, width of the pixel counter; must hold FRAME_PIXELS-1.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- vecIn  in  VECTOR_SIZE*OUTPUT_WIDTH  CPU out bus; lane i = bits [(i+1)*OUTPUT_WIDTH-1 : i*OUTPUT_WIDTH].
- vecValid  in  1  CPU outFlag; vecIn is valid this cycle.
- pixOut  out  OUTPUT_WIDTH  current pixel.
- pixValid  out  1  pixOut valid.
- pixReady  in  1  sink accepts pixOut.
- frameDone  out  1  one-cycle pulse after the last pixel of a frame is accepted.
- overflow  out  1  sticky; a vector was dropped.
- fifoLevel  out  $clog2(FIFO_DEPTH)+1  vectors currently stored in the FIFO.

Behaviour:
- Reset (async, active-high):
  - FIFO empty; fifoLevel=0.
  - pixOut=0, pixValid=0, frameDone=0, overflow=0.
  - Pixel counter=0, lane counter=0, state=IDLE.
  - Reset mid-frame discards all buffered data and restarts the pixel count.
- FIFO write:
  - Performed at the edge where vecValid=1, if fifoLevel<FIFO_DEPTH, or if fifoLevel==FIFO_DEPTH and a pop occurs in the same cycle.
  - Otherwise the vector is dropped and overflow is set to 1. It stays 1 until reset.
- FIFO pop: performed only by the serializer as defined below. Simultaneous push and pop leaves fifoLevel unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- Lane order: most-significant lane first (lane VECTOR_SIZE-1 down to lane 0). This matches the %b dump order of the CPU output.
- State machine (registered outputs):
  - IDLE: pixValid=0. If fifoLevel>0, pop the head into the shift register, set lane=0 and pixValid=1, and go to SEND.
  - SEND: pixOut = current lane; pixValid=1.
    - Beat accepted when pixValid&&pixReady.
    - On acceptance with lane<VECTOR_SIZE-1: advance lane and pixOut.
    - On acceptance of the last lane with fifoLevel>0: pop the next vector, set lane=0, stay in SEND. There is no bubble.
    - On acceptance of the last lane with fifoLevel=0: go to IDLE and clear pixValid.
  - While pixValid=1 && pixReady=0, pixOut and pixValid hold stable.
- Latency: a vector sampled at edge k (FIFO previously empty, serializer IDLE) gives pixValid=1 after edge k+1, with its first lane on pixOut. Sustained throughput is one pixel per cycle when pixReady=1.
- Pixel counter:
  - Increments on each accepted beat.
  - When the beat accepted has count==FRAME_PIXELS-1, the counter wraps to 0 and frameDone=1 for exactly the following cycle.
  - FRAME_PIXELS need not be a multiple of VECTOR_SIZE. The frame boundary may fall mid-vector; serialization continues unaffected.
- The CPU has no backpressure. With pixReady=1 continuously, the FIFO only overflows if the CPU issues vectors faster than one per VECTOR_SIZE cycles beyond FIFO_DEPTH.

Test Plan:
- Reset, then one vector vecIn=48'h0605_0403_0201 with pixReady=1 -> pixOut sequence 06,05,04,03,02,01 on 6 consecutive cycles starting 1 cycle after capture; then pixValid=0 and fifoLevel=0.
- Two vectors on back-to-back cycles, pixReady=1 -> 12 consecutive beats with no bubble between vectors; fifoLevel peaks at 1.
- pixReady=0 for 10 cycles while pixValid=1 on the first lane -> pixOut held constant, no beat counted; after release, full vector delivered in order.
- pixReady=0, 6 vectors issued -> first vector loaded in shift register, next 4 fill the FIFO (fifoLevel=4), 6th dropped and overflow=1. After release, exactly 30 pixels are delivered; overflow stays 1 until reset.
- FRAME_PIXELS=9, two vectors, pixReady=1 -> frameDone pulses one cycle after the 9th accepted beat, single cycle wide; the remaining 3 pixels are delivered and the counter ends at 3.
- Assert reset mid-serialization (lane 3, fifoLevel=2) -> pixValid=0 and fifoLevel=0 immediately, asynchronously; after reset a new vector is serialized from its first lane.

Source files
------------

// File: rtl/vector_output_serializer_if.sv
// Bundle of the CPU-facing vector port and the sink-facing pixel stream.
// The master modport is the serializer; the slave modport is its environment
// (the CPU plus the image sink).
interface vector_output_serializer_if #(
  parameter int VECTOR_SIZE  = 6,
  parameter int OUTPUT_WIDTH = 8,
  parameter int FIFO_DEPTH   = 4
) ();
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic [VECTOR_SIZE*OUTPUT_WIDTH-1:0] vecIn;
  logic                                vecValid;
  logic [OUTPUT_WIDTH-1:0]             pixOut;
  logic                                pixValid;
  logic                                pixReady;
  logic                                frameDone;
  logic                                overflow;
  logic [LEVEL_W-1:0]                  fifoLevel;

  modport master (
    input  vecIn, vecValid, pixReady,
    output pixOut, pixValid, frameDone, overflow, fifoLevel
  );

  modport slave (
    output vecIn, vecValid, pixReady,
    input  pixOut, pixValid, frameDone, overflow, fifoLevel
  );
endinterface

// File: rtl/vector_output_serializer.sv
// Captures CPU output vectors into a small FIFO and serializes them, most
// significant lane first, onto a valid/ready pixel stream. Counts pixels per
// frame, pulses frameDone after the last pixel of each frame, and flags
// vectors lost because the CPU cannot be stalled.
module vector_output_serializer #(
  parameter int VECTOR_SIZE  = 6,
  parameter int OUTPUT_WIDTH = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int FRAME_PIXELS = 76800,
  parameter int CNT_WIDTH    = 17
) (
  input  logic                           clock,
  input  logic                           reset,
  vector_output_serializer_if.master     bus
);
  localparam int VW      = VECTOR_SIZE * OUTPUT_WIDTH;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int LANE_W  = $clog2(VECTOR_SIZE + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [VW-1:0]           mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [LEVEL_W-1:0]      level;
  logic [VW-1:0]           head;
  logic [VW-1:0]           shreg;
  logic [LANE_W-1:0]       lane;
  logic [CNT_WIDTH-1:0]    pix_cnt;
  logic [0:0]              state;
  logic [OUTPUT_WIDTH-1:0] pix_q;
  logic                    valid_q;
  logic                    done_q;
  logic                    ovf_q;
  logic                    accept, last_lane, pop, push;

  // Handshake decode: a pop refills the shift register either from IDLE or
  // right as the last lane is taken, so back-to-back vectors have no bubble.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    accept    = 1'b0;
    last_lane = 1'b0;
    pop       = 1'b0;
    push      = 1'b0;
    head      = mem[rd_ptr];
    accept    = valid_q && bus.pixReady;
    last_lane = (lane == LANE_W'(VECTOR_SIZE - 1));
    pop       = (level != '0) && ((state == S_IDLE) || (accept && last_lane));
    push      = bus.vecValid && ((level != LEVEL_W'(FIFO_DEPTH)) || pop);
  end

  // FIFO storage: pure data, validity is tracked by the pointers and level.
  always_ff @(posedge clock) begin
    // NOTE: the storage array is deliberately left out of reset; only the
    // pointers and level define what is valid, so reset costs nothing here.
    if (push) mem[wr_ptr] <= bus.vecIn;
  end

  // FIFO bookkeeping and sticky overflow flag.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (bus.vecValid && !push) ovf_q <= 1'b1;
    end
  end

  // Serializer FSM with registered pixel outputs, MS lane first.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      shreg   <= '0;
      lane    <= '0;
      pix_q   <= '0;
      valid_q <= 1'b0;
    end else if (pop) begin
      pix_q   <= head[VW-1 -: OUTPUT_WIDTH];
      shreg   <= head << OUTPUT_WIDTH;
      lane    <= '0;
      valid_q <= 1'b1;
      state   <= S_SEND;
    end else if (accept) begin
      if (!last_lane) begin
        pix_q <= shreg[VW-1 -: OUTPUT_WIDTH];
        shreg <= shreg << OUTPUT_WIDTH;
        lane  <= lane + 1'b1;
      end else begin
        valid_q <= 1'b0;
        state   <= S_IDLE;
      end
    end
  end

  // Frame pixel counter; frameDone is high for the cycle after the last beat.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pix_cnt <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        if (pix_cnt == CNT_WIDTH'(FRAME_PIXELS - 1)) begin
          pix_cnt <= '0;
          done_q  <= 1'b1;
        end else begin
          pix_cnt <= pix_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.pixOut    = pix_q;
  assign bus.pixValid  = valid_q;
  assign bus.frameDone = done_q;
  assign bus.overflow  = ovf_q;
  assign bus.fifoLevel = level;
endmodule

// File: tb/tb_vector_output_serializer.sv
// Self-checking bench for vector_output_serializer. A queue-based reference
// model (vector queue + pending pixel queue + frame count) predicts every
// output after each clock edge; directed scenarios are followed by random
// traffic and a drain.
module tb_vector_output_serializer;
  localparam int VS = 6;
  localparam int OW = 8;
  localparam int FD = 4;
  localparam int FP = 9;
  localparam int CW = 17;
  localparam int VW = VS * OW;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  vector_output_serializer_if #(.VECTOR_SIZE(VS), .OUTPUT_WIDTH(OW), .FIFO_DEPTH(FD)) bus ();

  vector_output_serializer #(
    .VECTOR_SIZE(VS), .OUTPUT_WIDTH(OW), .FIFO_DEPTH(FD),
    .FRAME_PIXELS(FP), .CNT_WIDTH(CW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model state.
  logic [VW-1:0] m_fifo[$];
  logic [OW-1:0] m_pix[$];
  int            m_cnt;
  bit            m_ovf;
  bit            m_fd;

  int n_vec = 0;
  int n_err = 0;
  int beats;
  int peak;
  int n_fd;

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_pix.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
    m_fd  = 1'b0;
  endtask

  // One clock edge of the reference, using the inputs held across that edge.
  task automatic model_edge();
    logic [VW-1:0] v;
    m_fd = 1'b0;
    if (m_pix.size() > 0 && bus.pixReady) begin
      void'(m_pix.pop_front());
      if (m_cnt == FP - 1) begin
        m_cnt = 0;
        m_fd  = 1'b1;
      end else begin
        m_cnt++;
      end
    end
    if (m_pix.size() == 0 && m_fifo.size() > 0) begin
      v = m_fifo.pop_front();
      for (int i = VS - 1; i >= 0; i--) m_pix.push_back(v[i*OW +: OW]);
    end
    if (bus.vecValid) begin
      if (m_fifo.size() < FD) m_fifo.push_back(bus.vecIn);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic compare_all();
    check("pixValid", VW'(bus.pixValid), VW'(m_pix.size() > 0));
    if (m_pix.size() > 0) check("pixOut", VW'(bus.pixOut), VW'(m_pix[0]));
    check("fifoLevel", VW'(bus.fifoLevel), VW'(m_fifo.size()));
    check("overflow", VW'(bus.overflow), VW'(m_ovf));
    check("frameDone", VW'(bus.frameDone), VW'(m_fd));
  endtask

  task automatic step();
    if (bus.pixValid === 1'b1 && bus.pixReady) beats++;
    @(posedge clock);
    model_edge();
    #1;
    if (bus.frameDone === 1'b1) n_fd++;
    if (int'(bus.fifoLevel) > peak) peak = int'(bus.fifoLevel);
    compare_all();
  endtask

  task automatic send(input logic [VW-1:0] v);
    bus.vecIn    = v;
    bus.vecValid = 1'b1;
    step();
    bus.vecValid = 1'b0;
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[VW-1:0];
  endfunction

  initial begin
    logic [VW-1:0] v;
    reset        = 1'b1;
    bus.vecIn    = '0;
    bus.vecValid = 1'b0;
    bus.pixReady = 1'b0;
    beats = 0; peak = 0; n_fd = 0;
    model_reset();
    #12;
    check("rst_pixValid", VW'(bus.pixValid), '0);
    check("rst_pixOut", VW'(bus.pixOut), '0);
    check("rst_frameDone", VW'(bus.frameDone), '0);
    check("rst_overflow", VW'(bus.overflow), '0);
    check("rst_fifoLevel", VW'(bus.fifoLevel), '0);
    reset = 1'b0;
    step();

    // Single vector, sink always ready: 06..01 on consecutive cycles.
    bus.pixReady = 1'b1;
    send(48'h0605_0403_0201);
    check("t1_no_early_valid", VW'(bus.pixValid), '0);
    step();
    check("t1_first_lane", VW'(bus.pixOut), VW'(8'h06));
    repeat (7) step();
    check("t1_drained_valid", VW'(bus.pixValid), '0);
    check("t1_drained_level", VW'(bus.fifoLevel), '0);

    // Two back-to-back vectors: 12 beats, no bubble, level peaks at 1.
    beats = 0; peak = 0;
    send(rand_vec());
    send(rand_vec());
    repeat (13) step();
    check("t2_beats", VW'(beats), VW'(12));
    check("t2_peak", VW'(peak), VW'(1));

    // Sink stalls 10 cycles on the first lane.
    bus.pixReady = 1'b0;
    beats = 0;
    send(48'hA1B2_C3D4_E5F6);
    step();
    repeat (10) step();
    check("t3_held", VW'(bus.pixOut), VW'(8'hA1));
    check("t3_no_beats", VW'(beats), '0);
    bus.pixReady = 1'b1;
    repeat (8) step();
    check("t3_beats", VW'(beats), VW'(6));

    // Six vectors while stalled: 1 in shift register, 4 buffered, 1 dropped.
    bus.pixReady = 1'b0;
    for (int i = 0; i < 6; i++) send(rand_vec());
    check("t4_level", VW'(bus.fifoLevel), VW'(4));
    check("t4_overflow", VW'(bus.overflow), VW'(1));
    bus.pixReady = 1'b1;
    beats = 0;
    repeat (40) step();
    check("t4_beats", VW'(beats), VW'(30));
    check("t4_sticky", VW'(bus.overflow), VW'(1));

    // Frame boundary mid-vector from a fresh count.
    reset = 1'b1;
    #1;
    model_reset();
    #2;
    reset = 1'b0;
    step();
    n_fd = 0;
    send(rand_vec());
    send(rand_vec());
    repeat (15) step();
    check("t5_one_pulse", VW'(n_fd), VW'(1));
    send(rand_vec());
    repeat (8) step();
    check("t5_count_resumed_at_3", VW'(n_fd), VW'(2));

    // Reset mid-serialization at lane 3 with two vectors buffered.
    send(rand_vec());
    send(rand_vec());
    send(rand_vec());
    step();
    step();
    check("t6_pre_level", VW'(bus.fifoLevel), VW'(2));
    reset = 1'b1;
    #1;
    check("t6_async_valid", VW'(bus.pixValid), '0);
    check("t6_async_level", VW'(bus.fifoLevel), '0);
    model_reset();
    #2;
    reset = 1'b0;
    step();
    send(48'h1122_3344_5566);
    step();
    check("t6_restart_lane", VW'(bus.pixOut), VW'(8'h11));
    repeat (8) step();

    // Random traffic: light load then heavy load, random sink readiness.
    for (int i = 0; i < 1500; i++) begin
      bus.vecValid = ($urandom_range(0, 99) < 15);
      bus.vecIn    = rand_vec();
      bus.pixReady = ($urandom_range(0, 99) < 80);
      step();
    end
    for (int i = 0; i < 600; i++) begin
      bus.vecValid = ($urandom_range(0, 99) < 40);
      bus.vecIn    = rand_vec();
      bus.pixReady = ($urandom_range(0, 99) < 60);
      step();
    end
    bus.vecValid = 1'b0;
    bus.pixReady = 1'b1;
    repeat (40) step();
    check("end_drained", VW'(bus.pixValid), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
